// File: rtl/cu_multicycle.sv
// rtl/cu_multicycle.sv - multi-cycle control unit sequencing FETCH/DECODE/EXEC/MEM/WB
module cu_multicycle #(
  parameter int INSTR_W = 32,
  parameter int OP_W    = 6,
  parameter int REG_W   = 5,
  parameter int IMM_W   = 16,
  parameter int ALU_W   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  input  logic [1:0]         flags,
  input  logic               mem_ready,
  output logic               fetch_req,
  output logic [REG_W-1:0]   op1,
  output logic [REG_W-1:0]   op2,
  output logic [IMM_W-1:0]   imm,
  output logic [ALU_W-1:0]   alucode,
  output logic               imControl,
  output logic               regenable,
  output logic               mem_req,
  output logic               ramenable,
  output logic               pc_inc,
  output logic               pcControl,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_DIVI  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SR    = OP_W'(14);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_JE    = OP_W'(16);
  localparam logic [OP_W-1:0] OP_JB    = OP_W'(17);
  localparam logic [OP_W-1:0] OP_JA    = OP_W'(18);
  localparam logic [OP_W-1:0] OP_JNE   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_JBE   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_JAE   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_JZ    = OP_W'(22);
  localparam logic [OP_W-1:0] OP_JNZ   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_LOADI = OP_W'(25);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(26);
  localparam logic [OP_W-1:0] OP_MOV   = OP_W'(27);
  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(28);
  localparam logic [OP_W-1:0] OP_HLT   = OP_W'(29);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [OP_W-1:0]    op_q, op_in;
  logic               is_alu, is_jump, is_imm, is_mem, is_move, taken;
  logic [ALU_W-1:0]   alu_sel;

  logic               fetch_req_d, imcontrol_d, regenable_d, mem_req_d, ramenable_d;
  logic               pc_inc_d, pccontrol_d, halted_d, illegal_d;
  logic [ALU_W-1:0]   alucode_d;

  assign op_q  = ir_q[INSTR_W-1 -: OP_W];
  assign op_in = instruction[INSTR_W-1 -: OP_W];
  assign op1   = ir_q[INSTR_W-OP_W-1 -: REG_W];
  assign op2   = ir_q[INSTR_W-OP_W-REG_W-1 -: REG_W];
  assign imm   = ir_q[IMM_W-1:0];

  // Classify the latched opcode and pick its ALU operation and jump outcome.
  always_comb begin
    is_alu  = (op_q <= OP_SR);
    is_jump = (op_q >= OP_JMP) && (op_q <= OP_JNZ);
    is_imm  = ((op_q >= OP_ADDI) && (op_q <= OP_DIVI)) || (op_q == OP_LOADI);
    is_mem  = (op_q == OP_LOAD) || (op_q == OP_STORE);
    is_move = (op_q == OP_MOV) || (op_q == OP_LOADI);
    // flags = {below, zero}
    case (op_q)
      OP_JMP:        taken = 1'b1;
      OP_JE, OP_JZ:  taken = flags[0];
      OP_JNE, OP_JNZ: taken = !flags[0];
      OP_JB:         taken = flags[1];
      OP_JA:         taken = !flags[1] && !flags[0];
      OP_JBE:        taken = flags[1] || flags[0];
      OP_JAE:        taken = !flags[1];
      default:       taken = 1'b0;
    endcase
    case (op_q)
      OP_W'(0), OP_W'(4):  alu_sel = ALU_W'(0);
      OP_W'(1), OP_W'(5):  alu_sel = ALU_W'(1);
      OP_W'(2), OP_W'(6):  alu_sel = ALU_W'(2);
      OP_W'(3), OP_W'(7):  alu_sel = ALU_W'(3);
      OP_W'(8):            alu_sel = ALU_W'(4);
      OP_W'(9):            alu_sel = ALU_W'(5);
      OP_W'(10):           alu_sel = ALU_W'(6);
      OP_W'(11):           alu_sel = ALU_W'(7);
      OP_W'(12):           alu_sel = ALU_W'(8);
      OP_W'(13):           alu_sel = ALU_W'(9);
      OP_W'(14):           alu_sel = ALU_W'(10);
      OP_MOV, OP_LOADI:    alu_sel = ALU_W'(11);
      default:             alu_sel = '0;
    endcase
  end

  // Next state plus the output values for the cycle being entered, so every output is a flop.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    fetch_req_d = 1'b0;
    alucode_d   = '0;
    imcontrol_d = 1'b0;
    regenable_d = 1'b0;
    mem_req_d   = 1'b0;
    ramenable_d = 1'b0;
    pc_inc_d    = 1'b0;
    pccontrol_d = 1'b0;
    halted_d    = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // fetch_req is low for the first cycle after reset, so no handshake then
        if (fetch_req && instr_valid) begin
          ir_d    = instruction;
          state_d = S_DECODE;
          // NOP and illegal opcodes retire in DECODE, so their strobes are set up here
          if (op_in == OP_NOP) begin
            pc_inc_d = 1'b1;
          end else if (op_in > OP_HLT) begin
            pc_inc_d  = 1'b1;
            illegal_d = 1'b1;
          end
        end else begin
          fetch_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_alu) begin
          state_d     = S_EXEC;
          alucode_d   = alu_sel;
          imcontrol_d = is_imm;
        end else if (is_jump) begin
          state_d     = S_EXEC;
          pccontrol_d = taken;
          pc_inc_d    = !taken;
        end else if (is_mem) begin
          state_d     = S_MEM;
          mem_req_d   = 1'b1;
          ramenable_d = (op_q == OP_STORE);
        end else if (is_move) begin
          state_d     = S_WB;
          regenable_d = 1'b1;
          pc_inc_d    = 1'b1;
          alucode_d   = alu_sel;
          imcontrol_d = is_imm;
        end else if (op_q == OP_HLT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d     = S_FETCH;
          fetch_req_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_alu) begin
          state_d     = S_WB;
          regenable_d = 1'b1;
          pc_inc_d    = 1'b1;
          alucode_d   = alu_sel;
          imcontrol_d = is_imm;
        end else begin
          state_d     = S_FETCH;
          fetch_req_d = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          pc_inc_d = 1'b1;
          if (op_q == OP_LOAD) begin
            state_d     = S_WB;
            regenable_d = 1'b1;
          end else begin
            state_d     = S_FETCH;
            fetch_req_d = 1'b1;
          end
        end else begin
          mem_req_d   = 1'b1;
          ramenable_d = (op_q == OP_STORE);
        end
      end
      S_WB: begin
        state_d     = S_FETCH;
        fetch_req_d = 1'b1;
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, instruction register and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      fetch_req <= 1'b0;
      alucode   <= '0;
      imControl <= 1'b0;
      regenable <= 1'b0;
      mem_req   <= 1'b0;
      ramenable <= 1'b0;
      pc_inc    <= 1'b0;
      pcControl <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      fetch_req <= fetch_req_d;
      alucode   <= alucode_d;
      imControl <= imcontrol_d;
      regenable <= regenable_d;
      mem_req   <= mem_req_d;
      ramenable <= ramenable_d;
      pc_inc    <= pc_inc_d;
      pcControl <= pccontrol_d;
      halted    <= halted_d;
      illegal   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// tb/tb_cu_multicycle.sv - directed self-checking bench for cu_multicycle
module tb_cu_multicycle;

  logic        clock;
  logic        reset_n;

  logic [31:0] instruction;
  logic        instr_valid, mem_ready;
  logic [1:0]  flags;
  logic        fetch_req, imControl, regenable, mem_req, ramenable, pc_inc, pcControl, halted, illegal;
  logic [4:0]  op1, op2;
  logic [15:0] imm;
  logic [3:0]  alucode;

  logic [39:0] instruction_b;
  logic        instr_valid_b;
  logic        fetch_req_b, imControl_b, regenable_b, mem_req_b, ramenable_b, pc_inc_b, pcControl_b, halted_b, illegal_b;
  logic [5:0]  op1_b, op2_b;
  logic [19:0] imm_b;
  logic [3:0]  alucode_b;

  int tests = 0;
  int fails = 0;

  cu_multicycle dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction), .instr_valid(instr_valid),
    .flags(flags), .mem_ready(mem_ready), .fetch_req(fetch_req), .op1(op1), .op2(op2),
    .imm(imm), .alucode(alucode), .imControl(imControl), .regenable(regenable),
    .mem_req(mem_req), .ramenable(ramenable), .pc_inc(pc_inc), .pcControl(pcControl),
    .halted(halted), .illegal(illegal)
  );

  cu_multicycle #(.INSTR_W(40), .OP_W(6), .REG_W(6), .IMM_W(20), .ALU_W(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .instruction(instruction_b), .instr_valid(instr_valid_b),
    .flags(2'b00), .mem_ready(1'b0), .fetch_req(fetch_req_b), .op1(op1_b), .op2(op2_b),
    .imm(imm_b), .alucode(alucode_b), .imControl(imControl_b), .regenable(regenable_b),
    .mem_req(mem_req_b), .ramenable(ramenable_b), .pc_inc(pc_inc_b), .pcControl(pcControl_b),
    .halted(halted_b), .illegal(illegal_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int im);
    return {op[5:0], rd[4:0], rs[4:0], im[15:0]};
  endfunction

  initial begin
    reset_n       = 1'b0;
    instruction   = '0;
    instr_valid   = 1'b0;
    flags         = 2'b00;
    mem_ready     = 1'b0;
    instruction_b = '0;
    instr_valid_b = 1'b0;

    // reset state
    #12;
    check("rst_fetch_req", fetch_req, 0);
    check("rst_halted", halted, 0);
    check("rst_op1", op1, 0);
    check("rst_imm", imm, 0);
    check("rst_fetch_req_b", fetch_req_b, 0);
    tick;
    reset_n = 1'b1;
    check("release_no_fetch", fetch_req, 0);
    tick;
    check("release_fetch_req", fetch_req, 1);
    check("release_fetch_req_b", fetch_req_b, 1);

    // wide build: MOV rd=63 rs=62
    instruction_b = {6'd27, 6'd63, 6'd62, 2'b00, 20'hABCDE};
    instr_valid_b = 1'b1;
    tick;
    check("mov_b_op1", op1_b, 63);
    check("mov_b_op2", op2_b, 62);
    check("mov_b_imm", imm_b, 32'hABCDE);
    check("mov_b_decode_pc_inc", pc_inc_b, 0);
    instr_valid_b = 1'b0;
    tick;
    check("mov_b_wb_regen", regenable_b, 1);
    check("mov_b_wb_pc_inc", pc_inc_b, 1);
    check("mov_b_wb_alucode", alucode_b, 11);
    check("mov_b_wb_imctl", imControl_b, 0);
    tick;
    check("mov_b_refetch", fetch_req_b, 1);
    check("mov_b_regen_drop", regenable_b, 0);

    // ADDI rd=3 rs=1 imm=5 with instr_valid tied high
    instruction = enc(4, 3, 1, 5);
    instr_valid = 1'b1;
    check("addi_c1_fetch_req", fetch_req, 1);
    tick;
    check("addi_c2_fetch_req", fetch_req, 0);
    check("addi_op1", op1, 3);
    check("addi_op2", op2, 1);
    check("addi_imm", imm, 5);
    tick;
    check("addi_c3_alucode", alucode, 0);
    check("addi_c3_imctl", imControl, 1);
    check("addi_c3_regen", regenable, 0);
    tick;
    check("addi_c4_regen", regenable, 1);
    check("addi_c4_pc_inc", pc_inc, 1);
    check("addi_c4_imctl", imControl, 1);
    tick;
    check("addi_c5_fetch_req", fetch_req, 1);
    check("addi_c5_regen", regenable, 0);
    check("addi_c5_pc_inc", pc_inc, 0);

    // JA taken (flags 00)
    instruction = enc(18, 0, 0, 7);
    flags = 2'b00;
    tick;
    check("ja_t_decode_pcctl", pcControl, 0);
    tick;
    check("ja_t_pcctl", pcControl, 1);
    check("ja_t_pc_inc", pc_inc, 0);
    tick;
    check("ja_t_pcctl_drop", pcControl, 0);
    check("ja_t_refetch", fetch_req, 1);

    // JA not taken (zero set)
    flags = 2'b01;
    tick;
    tick;
    check("ja_n_pc_inc", pc_inc, 1);
    check("ja_n_pcctl", pcControl, 0);
    tick;
    check("ja_n_refetch", fetch_req, 1);

    // LOAD with mem_ready arriving in the 4th MEM cycle
    instruction = enc(24, 2, 4, 0);
    mem_ready = 1'b0;
    tick;
    check("load_decode_mem_req", mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("load_mem_req", mem_req, 1);
      check("load_ramenable", ramenable, 0);
      check("load_wait_regen", regenable, 0);
      if (i == 3) mem_ready = 1'b1;
    end
    tick;
    check("load_mem_req_drop", mem_req, 0);
    check("load_regen", regenable, 1);
    check("load_pc_inc", pc_inc, 1);
    instruction = enc(26, 2, 4, 0);
    tick;
    check("load_regen_drop", regenable, 0);
    check("load_refetch", fetch_req, 1);

    // STORE with immediate mem_ready
    tick;
    check("store_decode_mem_req", mem_req, 0);
    tick;
    check("store_mem_req", mem_req, 1);
    check("store_ramenable", ramenable, 1);
    tick;
    check("store_mem_req_drop", mem_req, 0);
    check("store_regen", regenable, 0);
    check("store_pc_inc", pc_inc, 1);
    check("store_refetch", fetch_req, 1);
    instruction = enc(45, 0, 0, 0);
    mem_ready = 1'b0;

    // illegal opcode 45
    tick;
    check("illegal_pulse", illegal, 1);
    check("illegal_pc_inc", pc_inc, 1);
    check("illegal_regen", regenable, 0);
    tick;
    check("illegal_drop", illegal, 0);
    check("illegal_refetch", fetch_req, 1);
    instruction = enc(28, 0, 0, 0);

    // NOP
    tick;
    check("nop_pc_inc", pc_inc, 1);
    check("nop_fetch_req", fetch_req, 0);
    tick;
    check("nop_refetch", fetch_req, 1);
    check("nop_pc_inc_drop", pc_inc, 0);
    instruction = enc(29, 0, 0, 0);

    // HLT
    tick;
    check("hlt_decode_halted", halted, 0);
    tick;
    check("hlt_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      instr_valid = ~instr_valid;
      tick;
      check("hlt_hold_halted", halted, 1);
      check("hlt_hold_fetch_req", fetch_req, 0);
      check("hlt_hold_pc_inc", pc_inc, 0);
    end

    // reset out of HALT, then async reset in the middle of a LOAD
    reset_n = 1'b0;
    #2;
    check("hlt_reset_halted", halted, 0);
    tick;
    reset_n = 1'b1;
    instruction = enc(24, 2, 4, 0);
    instr_valid = 1'b1;
    mem_ready = 1'b0;
    tick;
    check("rst2_fetch_req", fetch_req, 1);
    tick;
    tick;
    check("rst2_mem_req", mem_req, 1);
    check("rst2_op1", op1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_fetch_req", fetch_req, 0);
    check("async_op1", op1, 0);
    instr_valid = 1'b0;
    tick;
    reset_n = 1'b1;
    check("async_release_no_fetch", fetch_req, 0);
    tick;
    check("async_release_fetch_req", fetch_req, 1);
    check("async_release_mem_req", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
